// File: rtl/prog_instruction_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_instruction_memory_pkg
// Description : Shared definitions for the program instruction memory block.
//               Holds the controller state enumeration and the default
//               geometry constants used by the interface, the storage array
//               and the top-level controller.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_instruction_memory_pkg;

    localparam int IMEM_DATA_W = 32;   // default instruction word width
    localparam int IMEM_DEPTH  = 64;   // default number of instruction words
    localparam int IMEM_ADDR_W = 10;   // default fetch byte-address width

    // Controller states. The top level re-exports these as plain localparam
    // logic constants so the state register stays a simple vector.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_e;

endpackage : prog_instruction_memory_pkg
`default_nettype wire

// File: rtl/prog_instruction_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_instruction_memory_if
// Description : Load and fetch bus of the program instruction memory.
//               master : program loader / core side (drives requests)
//               slave  : instruction memory side (drives responses)
//   load_start/load_valid/load_data/load_last -> memory ; load_ready,
//   load_done <- memory ; fetch_req/fetch_addr -> memory ; fetch_valid,
//   instruction, fetch_err, busy, word_count <- memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_instruction_memory_if
    import prog_instruction_memory_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    localparam int WORD_AW = $clog2(DEPTH);

    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] instruction;
    logic              fetch_err;
    logic              busy;
    logic [WORD_AW:0]  word_count;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_ready, load_done,
        input  fetch_valid, instruction, fetch_err, busy, word_count
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_ready, load_done,
        output fetch_valid, instruction, fetch_err, busy, word_count
    );

endinterface : prog_instruction_memory_if
`default_nettype wire

// File: rtl/prog_instruction_memory_imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : Instruction storage with one synchronous write port and one
//               registered read port. The read register only updates when a
//               read is enabled, so the last read word is held otherwise.
//   clk, rst_n          : clock, asynchronous active-low reset (read reg only)
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read request
//   o_rdata             : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array
    import prog_instruction_memory_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [AW-1:0]     i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    // Storage carries no reset; its contents are defined by the controller's
    // clear sweep.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : imem_array
`default_nettype wire

// File: rtl/prog_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : prog_instruction_memory
// Description : Program instruction memory. After reset a clear sweep zeroes
//               every word, then the block accepts program-load sessions and
//               serves single-cycle-latency word fetches by byte address.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, re-enters the clear sweep
//   bus   : load/fetch bus (slave side), see prog_instruction_memory_if
// Revision    : 1.0 - initial release
// ============================================================================
module prog_instruction_memory
    import prog_instruction_memory_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    prog_instruction_memory_if.slave   bus
);

    localparam int WORD_AW = $clog2(DEPTH);

    localparam logic [1:0] S_CLEAR = ST_CLEAR;
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LOAD  = ST_LOAD;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WORD_AW-1:0] r_clr_ptr;
    logic [WORD_AW-1:0] r_wr_ptr;
    logic [WORD_AW:0]   r_word_count;
    logic               r_fetch_valid;
    logic               r_fetch_err;
    logic               r_rsp_err;     // last accepted fetch was an error

    logic               w_load_accept;
    logic               w_fetch_accept;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_addr_bad;
    logic               w_mem_we;
    logic [WORD_AW-1:0] w_mem_waddr;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic               w_mem_re;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_load_accept  = (r_state == S_LOAD) && bus.load_valid;
    assign w_fetch_accept = bus.fetch_req &&
                            ((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------
    // Fetch address check: byte address must be word aligned and the word
    // index must fall inside the array. When the address is exactly wide
    // enough to span the array there are no upper bits to inspect.
    // ------------------------------------------------------------------
    assign w_misaligned = |bus.fetch_addr[1:0];

    if (ADDR_W > WORD_AW + 2) begin : g_range_chk
        assign w_out_of_range = |bus.fetch_addr[ADDR_W-1:WORD_AW+2];
    end else begin : g_no_range_chk
        assign w_out_of_range = 1'b0;
    end

    assign w_addr_bad = w_misaligned || w_out_of_range;

    // ------------------------------------------------------------------
    // Controller FSM, pointers and session word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR;
            r_clr_ptr    <= '0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    // Pointer wraps back to zero on the last word, leaving it
                    // ready for the next clear sweep.
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state      <= S_LOAD;
                        r_wr_ptr     <= '0;
                        r_word_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_load_accept) begin
                        r_wr_ptr     <= r_wr_ptr + 1'b1;
                        r_word_count <= r_word_count + 1'b1;
                        // A full array ends the session even without
                        // load_last, so the pointer never runs past the end.
                        if (bus.load_last || (r_wr_ptr == LAST_IDX)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch response. The read register in the array and r_rsp_err both
    // update only on accepted fetches, so the instruction output holds its
    // last value between requests while fetch_valid/fetch_err drop to zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_accept;
            r_fetch_err   <= w_fetch_accept && w_addr_bad;
            if (w_fetch_accept) begin
                r_rsp_err <= w_addr_bad;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage write-port steering: clear sweep has priority (load words
    // cannot be accepted in CLEAR anyway).
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_wr_ptr;
        w_mem_wdata = bus.load_data;
        if (r_state == S_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_ptr;
            w_mem_wdata = '0;
        end else if (w_load_accept) begin
            w_mem_we    = 1'b1;
        end
    end

    assign w_mem_re = w_fetch_accept && !w_addr_bad;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (WORD_AW)
    ) u_imem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .i_raddr (bus.fetch_addr[WORD_AW+1:2]),
        .o_rdata (w_mem_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.load_ready  = (r_state == S_LOAD);
    assign bus.load_done   = (r_state == S_DONE);
    assign bus.busy        = (r_state == S_CLEAR) || (r_state == S_LOAD);
    assign bus.word_count  = r_word_count;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.instruction = r_rsp_err ? '0 : w_mem_rdata;

endmodule : prog_instruction_memory
`default_nettype wire

// File: tb/tb_prog_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_instruction_memory
// Description : Self-checking bench for prog_instruction_memory. A plain
//               array models the instruction store; expected fetch results
//               come from byte-address arithmetic on that array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_instruction_memory;
    import prog_instruction_memory_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prog_instruction_memory_if #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) bus ();

    prog_instruction_memory #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_instr;
    logic [31:0] q_words [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input int a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [9:0] rand_addr();
        int w;
        w = $urandom_range(0, DEPTH - 1);
        case ($urandom_range(0, 3))
            0, 1:    return 10'(w * 4);
            2:       return 10'(w * 4 + $urandom_range(1, 3));
            default: return 10'($urandom_range(DEPTH, 255) * 4 + $urandom_range(0, 3));
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Fetch one address and compare against the model one cycle later.
    task automatic do_fetch(input logic [9:0] a);
        logic [31:0] e_i;
        logic        e_err;
        e_err = addr_bad(int'(a));
        e_i   = e_err ? 32'h0 : model[int'(a) / 4];
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        step();
        bus.fetch_req  = 1'b0;
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(1));
        chk("fetch_err",   64'(bus.fetch_err),   64'(e_err));
        chk("instruction", 64'(bus.instruction), 64'(e_i));
        last_instr = e_i;
    endtask

    // Idle cycle after a fetch: no response, instruction held.
    task automatic idle_chk();
        step();
        chk("idle_valid", 64'(bus.fetch_valid), 64'(0));
        chk("idle_err",   64'(bus.fetch_err),   64'(0));
        chk("idle_hold",  64'(bus.instruction), 64'(last_instr));
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        chk("clear_cycles", 64'(cnt), 64'(DEPTH));
        chk("busy_after_clear", 64'(bus.busy), 64'(0));
    endtask

    // Run one load session. Words come from q_words first, then $urandom.
    // The session ends on load_last (when use_last) or when the array fills.
    task automatic run_load(input int n, input bit use_last, input bit gaps,
                            input bit started, input bit keep_valid);
        int          i;
        bit          done;
        logic [31:0] w;
        i    = 0;
        done = 1'b0;
        if (!started) begin
            bus.load_start = 1'b1;
            step();
            bus.load_start = 1'b0;
        end
        chk("ld_ready_enter", 64'(bus.load_ready), 64'(1));
        chk("wc_start",       64'(bus.word_count), 64'(0));
        while (!done) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.load_valid = 1'b0;
                bus.load_last  = 1'b0;
                step();
                chk("ld_ready_gap", 64'(bus.load_ready), 64'(1));
            end
            w = (q_words.size() > 0) ? q_words.pop_front() : 32'($urandom);
            bus.load_valid = 1'b1;
            bus.load_data  = w;
            bus.load_last  = use_last && (i == n - 1);
            step();
            model[i] = w;
            i++;
            if (bus.load_last || i == DEPTH) done = 1'b1;
        end
        bus.load_valid = keep_valid;
        bus.load_last  = 1'b0;
        chk("load_done_pulse", 64'(bus.load_done),  64'(1));
        chk("ld_ready_done",   64'(bus.load_ready), 64'(0));
        chk("word_count",      64'(bus.word_count), 64'(i));
        step();
        chk("load_done_end",   64'(bus.load_done),  64'(0));
        chk("busy_idle",       64'(bus.busy),       64'(0));
        chk("ld_ready_idle",   64'(bus.load_ready), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        last_instr     = '0;
        model_clear();

        // Reset values
        step(); step(); step();
        chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'(0));
        chk("rst_fetch_err",   64'(bus.fetch_err),   64'(0));
        chk("rst_instruction", 64'(bus.instruction), 64'(0));
        chk("rst_load_ready",  64'(bus.load_ready),  64'(0));
        chk("rst_load_done",   64'(bus.load_done),   64'(0));
        chk("rst_busy",        64'(bus.busy),        64'(1));
        chk("rst_word_count",  64'(bus.word_count),  64'(0));

        // Clear sweep length, then a fetch of word 0
        rst_n = 1'b1;
        wait_clear();
        do_fetch(10'h000);
        idle_chk();

        // Directed three-word program
        q_words.push_back(32'h2008_0020);
        q_words.push_back(32'h2009_0037);
        q_words.push_back(32'h0109_8024);
        run_load(3, 1'b1, 1'b0, 1'b0, 1'b0);
        do_fetch(10'h008);
        do_fetch(10'h000);
        do_fetch(10'h004);

        // Error addresses, then held-zero instruction
        do_fetch(10'h006);
        idle_chk();
        do_fetch(10'h100);
        do_fetch(10'h3FF);
        idle_chk();

        // Full-array stream with load_valid held high and no load_last
        run_load(DEPTH, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ld_ready_stay0", 64'(bus.load_ready), 64'(0));
        chk("wc_hold_64",     64'(bus.word_count), 64'(DEPTH));
        bus.load_valid = 1'b0;
        for (int k = 0; k < 24; k++) do_fetch(rand_addr());
        do_fetch(10'h0FC);
        idle_chk();

        // Short random session: untouched words keep their contents
        run_load(5, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) do_fetch(rand_addr());
        do_fetch(10'h014);

        // Fetch during LOAD is dropped
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 10'h008;
        step();
        bus.fetch_req  = 1'b0;
        chk("load_fetch_valid", 64'(bus.fetch_valid), 64'(0));
        chk("load_fetch_err",   64'(bus.fetch_err),   64'(0));
        run_load(2, 1'b1, 1'b0, 1'b1, 1'b0);

        // Fetch together with load_start: old word returned, LOAD entered
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 10'h00C;
        bus.load_start = 1'b1;
        step();
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b0;
        chk("joint_fetch_valid", 64'(bus.fetch_valid), 64'(1));
        chk("joint_fetch_err",   64'(bus.fetch_err),   64'(0));
        chk("joint_instruction", 64'(bus.instruction), 64'(model[3]));
        run_load(4, 1'b1, 1'b1, 1'b1, 1'b0);
        do_fetch(10'h00C);

        // Reset in the middle of a session
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'($urandom) | 32'h1;
            step();
        end
        bus.load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",       64'(bus.busy),        64'(1));
        chk("mid_rst_load_ready", 64'(bus.load_ready),  64'(0));
        chk("mid_rst_word_count", 64'(bus.word_count),  64'(0));
        chk("mid_rst_instr",      64'(bus.instruction), 64'(0));
        step();
        rst_n = 1'b1;
        model_clear();
        wait_clear();
        do_fetch(10'h004);
        for (int k = 0; k < 12; k++) do_fetch(rand_addr());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prog_instruction_memory
`default_nettype wire
